// File: rtl/bpu_pkg.sv
// Shared decode constants, instruction-trait struct and counter helpers for the
// branch prediction unit.
package bpu_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] FN_JR    = 6'h08;

    typedef struct packed {
        logic is_jr;
        logic is_branch;
        logic is_jal;
        logic is_jmp;
    } traits_t;

    // Weakly not-taken: MSB clear, one step below the taken threshold.
    function automatic int counter_init(input int cbits);
        return (1 << (cbits - 1)) - 1;
    endfunction

endpackage

// File: rtl/instr_decode.sv
// Control-flow trait decoder; purely combinational, one copy per pipe stage.
module instr_decode
    import bpu_pkg::*;
(
    input  logic [31:0] instr,
    output traits_t     traits
);

    logic [5:0]  op;
    logic [5:0]  fn;
    logic [19:0] unused_fields;

    assign op            = instr[31:26];
    assign fn            = instr[5:0];
    assign unused_fields = instr[25:6];

    always_comb begin
        traits           = '0;
        traits.is_jr     = (op == OP_RTYPE) && (fn == FN_JR);
        traits.is_branch = (op == OP_BEQ) || (op == OP_BNE);
        traits.is_jal    = (op == OP_JAL);
        traits.is_jmp    = (op == OP_J);
    end

endmodule

// File: rtl/branch_predict_unit.sv
// Fetch-stage next-PC predictor: direct-mapped BTB with saturating counters and
// an optional circular return-address stack, trained from EX.
module branch_predict_unit
    import bpu_pkg::*;
#(
    parameter int ENTRIES   = 64,
    parameter int CBITS     = 2,
    parameter int TAG_BITS  = 8,
    parameter int RAS_DEPTH = 4
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic [31:0] lookup_pc,
    input  logic [31:0] lookup_instr,
    output logic        pred_taken,
    output logic [31:0] pred_target,
    input  logic        update_valid,
    input  logic [31:0] update_pc,
    input  logic [31:0] update_instr,
    input  logic        update_taken,
    input  logic [31:0] update_target,
    input  logic        flush
);

    localparam int              IDX  = $clog2(ENTRIES);
    localparam logic [CBITS-1:0] INIT = CBITS'(counter_init(CBITS));
    localparam logic [CBITS-1:0] CMAX = '1;

    logic [ENTRIES-1:0]  valid_q;
    logic [TAG_BITS-1:0] tag_q [ENTRIES];
    logic [CBITS-1:0]    ctr_q [ENTRIES];
    logic [31:0]         tgt_q [ENTRIES];

    traits_t lt, ut;
    instr_decode u_dec_lookup (.instr(lookup_instr), .traits(lt));
    instr_decode u_dec_update (.instr(update_instr), .traits(ut));

    logic [IDX-1:0]      l_idx, u_idx;
    logic [TAG_BITS-1:0] l_tag, u_tag;
    logic                l_hit, u_hit;
    logic [31:0]         pc4;

    assign l_idx = lookup_pc[IDX+1:2];
    assign l_tag = lookup_pc[IDX+TAG_BITS+1:IDX+2];
    assign u_idx = update_pc[IDX+1:2];
    assign u_tag = update_pc[IDX+TAG_BITS+1:IDX+2];
    assign l_hit = valid_q[l_idx] && (tag_q[l_idx] == l_tag);
    assign u_hit = valid_q[u_idx] && (tag_q[u_idx] == u_tag);
    assign pc4   = lookup_pc + 32'd4;

    logic        ras_valid;
    logic [31:0] ras_top;
    logic        ras_push, ras_pop;
    logic        upd_en;
    logic        unused_upd;

    assign upd_en     = update_valid && !flush;
    assign ras_push   = upd_en && ut.is_jal;
    assign ras_pop    = upd_en && ut.is_jr;
    assign unused_upd = ^{update_pc, ut.is_jmp};

    always_comb begin
        pred_taken  = 1'b0;
        pred_target = pc4;
        if (lt.is_jmp || lt.is_jal) begin
            pred_taken  = 1'b1;
            pred_target = {pc4[31:28], lookup_instr[25:0], 2'b00};
        end else if (lt.is_branch) begin
            if (l_hit && ctr_q[l_idx][CBITS-1]) begin
                pred_taken  = 1'b1;
                pred_target = tgt_q[l_idx];
            end
        end else if (lt.is_jr) begin
            if (ras_valid) begin
                pred_taken  = 1'b1;
                pred_target = ras_top;
            end else if (l_hit) begin
                pred_taken  = 1'b1;
                pred_target = tgt_q[l_idx];
            end
        end
    end

    // Flush drops valid bits only; counters and targets survive for re-allocation.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            valid_q <= '0;
            for (int i = 0; i < ENTRIES; i++) begin
                tag_q[i] <= '0;
                ctr_q[i] <= INIT;
                tgt_q[i] <= '0;
            end
        end else if (flush) begin
            valid_q <= '0;
        end else if (update_valid) begin
            if (ut.is_branch) begin
                if (u_hit) begin
                    if (update_taken) begin
                        if (ctr_q[u_idx] != CMAX) ctr_q[u_idx] <= ctr_q[u_idx] + 1'b1;
                        tgt_q[u_idx] <= update_target;
                    end else if (ctr_q[u_idx] != '0) begin
                        ctr_q[u_idx] <= ctr_q[u_idx] - 1'b1;
                    end
                end else begin
                    valid_q[u_idx] <= 1'b1;
                    tag_q[u_idx]   <= u_tag;
                    ctr_q[u_idx]   <= update_taken ? INIT + 1'b1 : INIT;
                    tgt_q[u_idx]   <= update_target;
                end
            end else if (ut.is_jr) begin
                valid_q[u_idx] <= 1'b1;
                tag_q[u_idx]   <= u_tag;
                tgt_q[u_idx]   <= update_target;
            end
        end
    end

    generate
        if (RAS_DEPTH > 0) begin : g_ras
            localparam int PW = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
            localparam int CW = $clog2(RAS_DEPTH + 1);

            logic [31:0]   mem_q [RAS_DEPTH];
            logic [PW-1:0] top_q, top_inc, top_dec;
            logic [CW-1:0] cnt_q;

            assign top_inc   = (top_q == PW'(RAS_DEPTH - 1)) ? '0 : top_q + 1'b1;
            assign top_dec   = (top_q == '0) ? PW'(RAS_DEPTH - 1) : top_q - 1'b1;
            assign ras_valid = (cnt_q != '0);
            assign ras_top   = mem_q[top_q];

            // A push on a full stack lands on the oldest slot; count saturates.
            always_ff @(posedge clk or negedge resetn) begin
                if (!resetn) begin
                    top_q <= '0;
                    cnt_q <= '0;
                    for (int i = 0; i < RAS_DEPTH; i++) mem_q[i] <= '0;
                end else if (flush) begin
                    cnt_q <= '0;
                end else if (ras_push) begin
                    top_q          <= top_inc;
                    mem_q[top_inc] <= update_pc + 32'd4;
                    if (cnt_q != CW'(RAS_DEPTH)) cnt_q <= cnt_q + 1'b1;
                end else if (ras_pop && ras_valid) begin
                    top_q <= top_dec;
                    cnt_q <= cnt_q - 1'b1;
                end
            end
        end else begin : g_no_ras
            logic unused_ras;
            assign ras_valid  = 1'b0;
            assign ras_top    = '0;
            assign unused_ras = ^{ras_push, ras_pop};
        end
    endgenerate

endmodule

// File: tb/tb_branch_predict_unit.sv
// Directed scenarios plus randomized traffic against a queue/array predictor model.
module tb_branch_predict_unit;

    localparam int ENTRIES   = 64;
    localparam int CBITS     = 2;
    localparam int TAG_BITS  = 8;
    localparam int RAS_DEPTH = 4;
    localparam int IDX       = $clog2(ENTRIES);
    localparam int INIT      = (1 << (CBITS - 1)) - 1;
    localparam int CMAX      = (1 << CBITS) - 1;

    localparam logic [31:0] I_J    = 32'h0800_0000;
    localparam logic [31:0] I_JAL  = 32'h0C00_0000;
    localparam logic [31:0] I_BEQ  = 32'h1000_0000;
    localparam logic [31:0] I_BNE  = 32'h1400_0000;
    localparam logic [31:0] I_JR   = 32'h03E0_0008;
    localparam logic [31:0] I_ADDU = 32'h0000_0021;
    localparam logic [31:0] I_LW   = 32'h8C00_0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] lookup_pc = '0, lookup_instr = '0;
    logic        pred_taken;
    logic [31:0] pred_target;
    logic        update_valid = 1'b0;
    logic [31:0] update_pc = '0, update_instr = '0, update_target = '0;
    logic        update_taken = 1'b0;
    logic        flush = 1'b0;

    int checks   = 0;
    int failures = 0;

    branch_predict_unit #(
        .ENTRIES(ENTRIES), .CBITS(CBITS), .TAG_BITS(TAG_BITS), .RAS_DEPTH(RAS_DEPTH)
    ) dut (
        .clk(clk), .resetn(rst_n),
        .lookup_pc(lookup_pc), .lookup_instr(lookup_instr),
        .pred_taken(pred_taken), .pred_target(pred_target),
        .update_valid(update_valid), .update_pc(update_pc), .update_instr(update_instr),
        .update_taken(update_taken), .update_target(update_target), .flush(flush)
    );

    always #5 clk = ~clk;

    // Reference model: plain arrays for the BTB, a queue for the return stack
    // (back = most recent, front dropped when it overflows).
    bit          m_valid [ENTRIES];
    int unsigned m_tag   [ENTRIES];
    int unsigned m_ctr   [ENTRIES];
    logic [31:0] m_tgt   [ENTRIES];
    logic [31:0] m_ras   [$];

    function automatic int unsigned idx_of(input logic [31:0] pc);
        return (pc >> 2) % ENTRIES;
    endfunction

    function automatic int unsigned tag_of(input logic [31:0] pc);
        return (pc >> (IDX + 2)) % (1 << TAG_BITS);
    endfunction

    function automatic int unsigned opc(input logic [31:0] ins);
        return ins >> 26;
    endfunction

    function automatic bit is_jr_i(input logic [31:0] ins);
        return opc(ins) == 0 && (ins % 64) == 8;
    endfunction

    function automatic bit is_br_i(input logic [31:0] ins);
        return opc(ins) == 4 || opc(ins) == 5;
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < ENTRIES; i++) begin
            m_valid[i] = 0; m_tag[i] = 0; m_ctr[i] = INIT; m_tgt[i] = 0;
        end
        m_ras.delete();
    endfunction

    function automatic void model_step();
        int unsigned i;
        bit hit;
        i   = idx_of(update_pc);
        hit = m_valid[i] && m_tag[i] == tag_of(update_pc);
        if (flush) begin
            for (int k = 0; k < ENTRIES; k++) m_valid[k] = 0;
            m_ras.delete();
        end else if (update_valid) begin
            if (is_br_i(update_instr)) begin
                if (hit) begin
                    if (update_taken) begin
                        if (m_ctr[i] < CMAX) m_ctr[i]++;
                        m_tgt[i] = update_target;
                    end else if (m_ctr[i] > 0) begin
                        m_ctr[i]--;
                    end
                end else begin
                    m_valid[i] = 1; m_tag[i] = tag_of(update_pc);
                    m_ctr[i] = update_taken ? INIT + 1 : INIT;
                    m_tgt[i] = update_target;
                end
            end else if (is_jr_i(update_instr)) begin
                m_valid[i] = 1; m_tag[i] = tag_of(update_pc); m_tgt[i] = update_target;
                if (m_ras.size() > 0) void'(m_ras.pop_back());
            end else if (opc(update_instr) == 3) begin
                m_ras.push_back(update_pc + 32'd4);
                if (m_ras.size() > RAS_DEPTH) void'(m_ras.pop_front());
            end
        end
    endfunction

    function automatic void model_pred(input logic [31:0] pc, input logic [31:0] ins,
                                       output bit tk, output logic [31:0] tg);
        int unsigned i;
        bit hit;
        logic [31:0] pc4;
        pc4 = pc + 32'd4;
        i   = idx_of(pc);
        hit = m_valid[i] && m_tag[i] == tag_of(pc);
        tk  = 0;
        tg  = pc4;
        if (opc(ins) == 2 || opc(ins) == 3) begin
            tk = 1;
            tg = (pc4 & 32'hF000_0000) | ((ins & 32'h03FF_FFFF) << 2);
        end else if (is_br_i(ins)) begin
            if (hit && m_ctr[i] >= (1 << (CBITS - 1))) begin tk = 1; tg = m_tgt[i]; end
        end else if (is_jr_i(ins)) begin
            if (m_ras.size() > 0) begin tk = 1; tg = m_ras[$]; end
            else if (hit)         begin tk = 1; tg = m_tgt[i]; end
        end
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) model_reset();
        else        model_step();
    end

    // Drive one cycle's inputs at the falling edge; outputs settle 1 time unit later,
    // and the update commits at the following rising edge.
    task automatic drive(input logic [31:0] lpc, input logic [31:0] lins, input logic uv,
                         input logic [31:0] upc, input logic [31:0] uins, input logic utk,
                         input logic [31:0] utgt, input logic fl);
        @(negedge clk);
        lookup_pc = lpc; lookup_instr = lins;
        update_valid = uv; update_pc = upc; update_instr = uins;
        update_taken = utk; update_target = utgt; flush = fl;
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        lookup_pc = 32'h0040_0010; lookup_instr = I_BEQ;
        update_valid = 1'b1; update_pc = 32'h0040_0010; update_instr = I_BEQ;
        update_taken = 1'b1; update_target = 32'h0040_0000;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if (pred_taken !== 1'b0) begin
            failures++; $display("FAIL reset_taken got=%0b exp=0", pred_taken);
        end
        update_valid = 1'b0;
        rst_n = 1'b1;
        drive(32'h0040_0010, I_BEQ, 0, 0, 0, 0, 0, 0);
        checks++;
        if (pred_taken !== 1'b0 || pred_target !== 32'h0040_0014) begin
            failures++;
            $display("FAIL reset_beq got=%0b/%h exp=0/00400014", pred_taken, pred_target);
        end
        drive(32'h0040_0010, I_J | 32'h0100004, 0, 0, 0, 0, 0, 0);
        checks++;
        if (pred_taken !== 1'b1 || pred_target !== 32'h0040_0010) begin
            failures++;
            $display("FAIL jump_target got=%0b/%h exp=1/00400010", pred_taken, pred_target);
        end
    endtask

    task automatic test_counter();
        logic [31:0] a;
        a = 32'h0040_0010;
        drive(a, I_BEQ, 1, a, I_BEQ, 1, 32'h0040_0000, 0);
        drive(a, I_BEQ, 1, a, I_BEQ, 1, 32'h0040_0000, 0);
        drive(a, I_BEQ, 0, 0, 0, 0, 0, 0);
        checks++;
        if (pred_taken !== 1'b1 || pred_target !== 32'h0040_0000) begin
            failures++;
            $display("FAIL train_taken got=%0b/%h exp=1/00400000", pred_taken, pred_target);
        end
        repeat (3) drive(a, I_BEQ, 1, a, I_BNE, 0, 32'h0040_0000, 0);
        drive(a, I_BEQ, 0, 0, 0, 0, 0, 0);
        checks++;
        if (pred_taken !== 1'b0 || pred_target !== 32'h0040_0014) begin
            failures++;
            $display("FAIL train_not_taken got=%0b/%h exp=0/00400014", pred_taken, pred_target);
        end
    endtask

    task automatic test_alias();
        logic [31:0] a, b;
        a = 32'h0040_0010;
        b = a + ENTRIES * 4;
        drive(a, I_BEQ, 1, a, I_BEQ, 1, 32'h0040_0000, 0);
        drive(b, I_BEQ, 1, b, I_BEQ, 1, 32'h0050_0000, 0);
        drive(a, I_BEQ, 0, 0, 0, 0, 0, 0);
        checks++;
        if (pred_taken !== 1'b0 || pred_target !== a + 32'd4) begin
            failures++;
            $display("FAIL alias_evicted got=%0b/%h exp=0/%h", pred_taken, pred_target, a + 32'd4);
        end
        drive(b, I_BNE, 0, 0, 0, 0, 0, 0);
        checks++;
        if (pred_taken !== 1'b1 || pred_target !== 32'h0050_0000) begin
            failures++;
            $display("FAIL alias_new got=%0b/%h exp=1/00500000", pred_taken, pred_target);
        end
    endtask

    task automatic test_ras();
        logic [31:0] exp_t;
        for (int k = 1; k <= 5; k++)
            drive(0, I_ADDU, 1, 32'(k * 'h100), I_JAL, 1, 0, 0);
        for (int k = 5; k >= 2; k--) begin
            exp_t = 32'(k * 'h100 + 4);
            drive(32'h600, I_JR, 1, 32'h600, I_JR, 1, exp_t, 0);
            checks++;
            if (pred_taken !== 1'b1 || pred_target !== exp_t) begin
                failures++;
                $display("FAIL ras_pop_%0d got=%0b/%h exp=1/%h", k, pred_taken, pred_target, exp_t);
            end
        end
        drive(32'h700, I_JR, 0, 0, 0, 0, 0, 0);
        checks++;
        if (pred_taken !== 1'b0 || pred_target !== 32'h704) begin
            failures++;
            $display("FAIL ras_empty got=%0b/%h exp=0/00000704", pred_taken, pred_target);
        end
        drive(32'h600, I_JR, 0, 0, 0, 0, 0, 0);
        checks++;
        if (pred_taken !== 1'b1 || pred_target !== 32'h204) begin
            failures++;
            $display("FAIL jr_btb_fallback got=%0b/%h exp=1/00000204", pred_taken, pred_target);
        end
    endtask

    task automatic test_same_cycle();
        logic [31:0] b;
        b = 32'h0040_0020;
        drive(b, I_BEQ, 1, b, I_BEQ, 0, 32'h0040_1000, 0);
        drive(b, I_BEQ, 1, b, I_BEQ, 1, 32'h0040_1000, 0);
        checks++;
        if (pred_taken !== 1'b0 || pred_target !== b + 32'd4) begin
            failures++;
            $display("FAIL same_cycle_old got=%0b/%h exp=0/%h", pred_taken, pred_target, b + 32'd4);
        end
        drive(b, I_BEQ, 0, 0, 0, 0, 0, 0);
        checks++;
        if (pred_taken !== 1'b1 || pred_target !== 32'h0040_1000) begin
            failures++;
            $display("FAIL same_cycle_new got=%0b/%h exp=1/00401000", pred_taken, pred_target);
        end
    endtask

    task automatic test_flush();
        logic [31:0] b;
        b = 32'h0040_0020;
        drive(b, I_BEQ, 1, 32'h800, I_JAL, 1, 0, 0);
        drive(b, I_BEQ, 1, b, I_BEQ, 0, 32'h0040_1000, 1);
        drive(b, I_BEQ, 0, 0, 0, 0, 0, 0);
        checks++;
        if (pred_taken !== 1'b0 || pred_target !== b + 32'd4) begin
            failures++;
            $display("FAIL flush_miss got=%0b/%h exp=0/%h", pred_taken, pred_target, b + 32'd4);
        end
        drive(32'h900, I_JR, 1, b, I_JR, 1, 32'h0040_2000, 0);
        checks++;
        if (pred_taken !== 1'b0 || pred_target !== 32'h904) begin
            failures++;
            $display("FAIL flush_ras got=%0b/%h exp=0/00000904", pred_taken, pred_target);
        end
        drive(b, I_BEQ, 0, 0, 0, 0, 0, 0);
        checks++;
        if (pred_taken !== 1'b1 || pred_target !== 32'h0040_2000) begin
            failures++;
            $display("FAIL flush_ctr_kept got=%0b/%h exp=1/00402000", pred_taken, pred_target);
        end
    endtask

    function automatic logic [31:0] rand_instr();
        case ($urandom_range(0, 6))
            0: return I_BEQ | ($urandom & 32'h03FF_FFFF);
            1: return I_BNE | ($urandom & 32'h03FF_FFFF);
            2: return I_JR;
            3: return I_JAL | ($urandom & 32'h03FF_FFFF);
            4: return I_J   | ($urandom & 32'h03FF_FFFF);
            5: return I_ADDU | ($urandom & 32'h03FF_F800);
            default: return I_LW | ($urandom & 32'h03FF_FFFF);
        endcase
    endfunction

    task automatic test_random();
        logic [31:0] pool [8];
        logic [31:0] lpc, lins, exp_tg;
        bit          exp_tk;
        pool = '{32'h1000, 32'h1004, 32'h1100, 32'h2100,
                 32'h1008, 32'h4000_1000, 32'h3000, 32'h1104};
        for (int n = 0; n < 400; n++) begin
            lpc  = pool[$urandom_range(0, 7)];
            lins = rand_instr();
            drive(lpc, lins, $urandom_range(0, 9) < 7, pool[$urandom_range(0, 7)], rand_instr(),
                  1'($urandom), $urandom & 32'hFFFF_FFFC, $urandom_range(0, 29) == 0);
            model_pred(lpc, lins, exp_tk, exp_tg);
            checks++;
            if (pred_taken !== exp_tk || pred_target !== exp_tg) begin
                failures++;
                $display("FAIL random_%0d pc=%h ins=%h got=%0b/%h exp=%0b/%h",
                         n, lpc, lins, pred_taken, pred_target, exp_tk, exp_tg);
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_counter();
        test_alias();
        test_ras();
        test_same_cycle();
        test_flush();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/branch_predict_unit.md
Name: branch_predict_unit

Overview:
- Parametrised successor to the fetch-stage instruction-trait decoder.
- Decodes control-flow traits (JR, BEQ/BNE, JAL, J) of the fetched instruction and produces a next-PC prediction.
- Keeps state across cycles: a direct-mapped branch target buffer (BTB) with saturating counters, plus an optional return-address stack (RAS).
- Lookup sits in IF; training arrives from EX at resolve time.

Parameters:
- ENTRIES, 64, BTB entries; power of two, >= 2; IDX = log2(ENTRIES).
- CBITS, 2, saturating-counter width, 1..4.
- TAG_BITS, 8, stored tag width; IDX+TAG_BITS <= 30.
- RAS_DEPTH, 4, return-stack depth; 0 removes the RAS (JR falls back to the BTB).

Ports:
- clk  in  1  clock, rising edge.
- resetn  in  1  asynchronous, active-low reset.
- lookup_pc  in  32  PC of the instruction in IF.
- lookup_instr  in  32  instruction word at lookup_pc.
- pred_taken  out  1  predict redirect.
- pred_target  out  32  predicted next PC; lookup_pc+4 when not taken.
- update_valid  in  1  EX resolves a control-flow instruction this cycle.
- update_pc  in  32  PC of the resolved instruction.
- update_instr  in  32  resolved instruction word.
- update_taken  in  1  actual direction.
- update_target  in  32  actual target.
- flush  in  1  invalidate all predictor state except counters.

Behaviour:
- Address split: idx = pc[IDX+1:2]; tag = pc[IDX+TAG_BITS+1:IDX+2]; hit = valid[idx] && tag[idx]==tag.
- Counter init value: INIT = 2^(CBITS-1)-1 (weakly not-taken). Predict taken when counter MSB = 1.
- Lookup is purely combinational on lookup_pc, lookup_instr and current state (0-cycle latency).
  - J/JAL: taken; target = {pc4[31:28], instr[25:0], 2'b00}, where pc4 = lookup_pc+4. No table access.
  - BEQ/BNE: taken iff hit && counter MSB; target = stored target.
  - JR: RAS non-empty -> taken, target = RAS top. Else BTB hit -> taken, stored target. Else not taken.
  - Any other instruction: not taken, target = lookup_pc+4.
- Update takes one cycle. Writes land on the rising edge; a lookup in the same cycle to the same idx sees the pre-update state.
  - Branch, hit: counter +1 if taken, -1 if not, saturating at 0 and 2^CBITS-1. Target rewritten when taken.
  - Branch, miss: allocate the entry (valid=1, tag written). Counter = INIT+1 if taken, else INIT. Target = update_target.
  - JR: allocate or overwrite the entry with target = update_target; counter untouched. Pop the RAS if non-empty; popping an empty RAS is a no-op.
  - JAL: push update_pc+4 onto the RAS. The pipeline has no delay slot.
  - J or non-control instructions: no state change.
- RAS is a circular buffer with a top pointer and a count.
  - Push when full overwrites the oldest entry; count saturates at RAS_DEPTH.
  - Pointer arithmetic wraps modulo RAS_DEPTH.
- flush clears all valid bits and the RAS count in one cycle. Counters and targets are retained. flush has priority over a same-cycle update, which is dropped.
- Reset, asynchronous: valid = 0, counters = INIT, targets = 0, RAS count/pointer = 0.
  - Outputs after reset: pred_taken = 0 for all non-J/JAL instructions; pred_target = lookup_pc+4.
  - Reset mid-update: the update is discarded.
- Lookup and update use separate decode instances; no structural hazard.

Decomposition:
- Package bpu_pkg holds:
  - opcode/funct constants (RTYPE, JR, BEQ, BNE, JAL, J);
  - typedef traits_t, a packed struct {is_jr, is_branch, is_jal, is_jmp};
  - function counter_init(CBITS).
- Sub-module instr_decode: instr -> traits_t, purely combinational, instantiated twice (lookup and update).
- RAS stays inline; keeping it inline lets RAS_DEPTH=0 remove it through a generate block.

Test Plan:
- Reset, then lookup BEQ at 0x0040_0010 -> pred_taken=0, pred_target=0x0040_0014. Lookup J with instr[25:0]=0x0100004 -> taken, target 0x0040_0010.
- Update the BEQ taken to 0x0040_0000 twice, then lookup -> pred_taken=1, target 0x0040_0000. Next, three not-taken updates -> counter = 0, pred_taken=0.
- Update a branch whose PC aliases to the same idx with a different tag -> entry replaced. The original PC then misses and predicts pc+4.
- JAL updates at 0x100, 0x200, 0x300, 0x400, 0x500 (RAS_DEPTH=4), then JR lookups/pops -> targets 0x504, 0x404, 0x304, 0x204; RAS empty afterwards.
- Same-cycle update and lookup of the same idx -> lookup reflects the old counter; the following cycle reflects the new one.
- flush asserted together with update_valid -> all lookups miss next cycle. Update dropped; counters keep their prior values, observed via re-allocation without a counter reset.
